// File: rtl/formula_res_buf_pkg.sv
// ============================================================================
// Module : formula_res_buf_pkg
// Shared defaults, pointer-width helper and result type for the result buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package formula_res_buf_pkg;

  localparam int c_default_width = 32;
  localparam int c_default_depth = 16;

  typedef logic [31:0] res_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/formula_res_fifo.sv
// ============================================================================
// Module : formula_res_fifo
// Result FIFO with wrap-bit pointers, registered level and sticky overflow.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module formula_res_fifo
  import formula_res_buf_pkg::*;
#(
  parameter int WIDTH = c_default_width,
  parameter int DEPTH = c_default_depth,
  parameter int CNT_W = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [CNT_W-1:0] level,
  output logic             overflow
);

  localparam int               c_idx_w = CNT_W - 1;
  localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_level;
  logic             r_overflow;

  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic [CNT_W-1:0] w_wr_nxt;
  logic [CNT_W-1:0] w_rd_nxt;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[c_idx_w-1:0] == r_rd_ptr[c_idx_w-1:0]) &&
                    (r_wr_ptr[CNT_W-1] != r_rd_ptr[CNT_W-1]);
  assign w_pop    = pop && !w_empty;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
  assign w_push   = push && (!w_full || w_pop);
  assign w_wr_nxt = w_push ? (r_wr_ptr + c_one) : r_wr_ptr;
  assign w_rd_nxt = w_pop  ? (r_rd_ptr + c_one) : r_rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_level  <= w_wr_nxt - w_rd_nxt;
      if (push && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_idx_w-1:0]] <= wr_data;
    end
  end

  assign rd_data  = r_mem[r_rd_ptr[c_idx_w-1:0]];
  assign empty    = w_empty;
  assign level    = r_level;
  assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: rtl/formula_res_credit_buf.sv
// ============================================================================
// Module : formula_res_credit_buf
// Credit-gated issue for a no-backpressure pipe plus result FIFO drain.
// Optional perf counters: define FORMULA_RES_BUF_PERF_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module formula_res_credit_buf
  import formula_res_buf_pkg::*;
#(
  parameter int WIDTH = c_default_width,
  parameter int DEPTH = c_default_depth,
  parameter int CNT_W = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_vld,
  output logic             up_rdy,
  output logic             issue_vld,
  input  logic             pipe_res_vld,
  input  logic [WIDTH-1:0] pipe_res,
  output logic             down_vld,
  input  logic             down_rdy,
  output logic [WIDTH-1:0] down_data,
  output logic [CNT_W-1:0] level,
  output logic             overflow
`ifdef FORMULA_RES_BUF_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      drain_stall_cnt
`endif
);

  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_credits = CNT_W'(DEPTH);

  logic [CNT_W-1:0] r_credits;
  logic             w_issue;
  logic             w_pop;
  logic             w_empty;

  assign up_rdy    = (r_credits != '0);
  assign w_issue   = up_vld && up_rdy;
  assign issue_vld = w_issue;
  assign down_vld  = !w_empty;
  assign w_pop     = down_vld && down_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_credits <= c_credits;
    end else if (w_issue && !w_pop) begin
      r_credits <= r_credits - c_one;
    end else if (!w_issue && w_pop) begin
      r_credits <= r_credits + c_one;
    end
  end

`ifndef SYNTHESIS
  // Unsigned underflow would wrap above DEPTH, so one bound covers both limits.
  a_credit_bounds: assert property (@(posedge clk) disable iff (!rst)
    (r_credits <= c_credits));
`endif

  formula_res_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (pipe_res_vld),
    .pop      (w_pop),
    .wr_data  (pipe_res),
    .rd_data  (down_data),
    .empty    (w_empty),
    .level    (level),
    .overflow (overflow)
  );

`ifdef FORMULA_RES_BUF_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_drain_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt       <= '0;
      r_drain_stall_cnt <= '0;
    end else begin
      if (up_vld && !up_rdy && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (down_vld && !down_rdy && (r_drain_stall_cnt != '1)) begin
        r_drain_stall_cnt <= r_drain_stall_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt       = r_stall_cnt;
  assign drain_stall_cnt = r_drain_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_formula_res_credit_buf.sv
// ============================================================================
// Module : tb_formula_res_credit_buf
// Self-checking bench: fixed-latency pipe stand-in, queue reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_formula_res_credit_buf;

  localparam int c_width = 32;
  localparam int c_depth = 16;
  localparam int c_cnt_w = 5;
  localparam int c_lat   = 7;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               up_vld = 1'b0;
  logic               up_rdy;
  logic               issue_vld;
  logic               pipe_res_vld;
  logic [c_width-1:0] pipe_res;
  logic               down_vld;
  logic               down_rdy = 1'b0;
  logic [c_width-1:0] down_data;
  logic [c_cnt_w-1:0] level;
  logic               overflow;
  logic               force_vld = 1'b0;
  logic [c_width-1:0] force_data = '0;
`ifdef FORMULA_RES_BUF_PERF_CNT_EN
  logic [31:0]        stall_cnt;
  logic [31:0]        drain_stall_cnt;
`endif

  always #5 clk = ~clk;

  formula_res_credit_buf dut (
    .clk             (clk),
    .rst             (rst),
    .up_vld          (up_vld),
    .up_rdy          (up_rdy),
    .issue_vld       (issue_vld),
    .pipe_res_vld    (pipe_res_vld),
    .pipe_res        (pipe_res),
    .down_vld        (down_vld),
    .down_rdy        (down_rdy),
    .down_data       (down_data),
    .level           (level),
    .overflow        (overflow)
`ifdef FORMULA_RES_BUF_PERF_CNT_EN
    ,
    .stall_cnt       (stall_cnt),
    .drain_stall_cnt (drain_stall_cnt)
`endif
  );

  function automatic logic [31:0] res_fn(input logic [31:0] a);
    return a * 32'h9E37_79B9 + 32'd1;
  endfunction

  // Pipe stand-in: result for the k-th issued argument appears c_lat cycles later.
  logic        pv [c_lat];
  logic [31:0] pd [c_lat];
  logic [31:0] arg_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < c_lat; i++) begin
        pv[i] <= 1'b0;
        pd[i] <= '0;
      end
      arg_cnt <= '0;
    end else begin
      pv[0] <= issue_vld;
      pd[0] <= res_fn(arg_cnt);
      if (issue_vld) arg_cnt <= arg_cnt + 32'd1;
      for (int i = 1; i < c_lat; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign pipe_res_vld = force_vld | pv[c_lat-1];
  assign pipe_res     = force_vld ? force_data : pd[c_lat-1];

  // Reference model.
  int          n_cmp = 0;
  int          n_err = 0;
  int          m_credits;
  logic [31:0] m_q[$];
  bit          m_ovf;
  longint      m_stall;
  longint      m_drain;
  int          n_issue;
  int          n_pop;
  bit          streaming;
  bit          no_dead;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_credits = c_depth;
    m_q.delete();
    m_ovf     = 1'b0;
    m_stall   = 0;
    m_drain   = 0;
    n_issue   = 0;
    n_pop     = 0;
  endtask

  task automatic model_cycle();
    bit exp_rdy, exp_iss, exp_dv, pop, full;
    exp_rdy = (m_credits != 0);
    exp_iss = up_vld && exp_rdy;
    exp_dv  = (m_q.size() != 0);
    chk("up_rdy", up_rdy, exp_rdy);
    chk("issue_vld", issue_vld, exp_iss);
    chk("down_vld", down_vld, exp_dv);
    chk("level", level, m_q.size());
    chk("overflow", overflow, m_ovf);
    if (exp_dv) chk("down_data", down_data, m_q[0]);
`ifdef FORMULA_RES_BUF_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("drain_stall_cnt", drain_stall_cnt, m_drain);
`endif
    if (no_dead && down_vld) chk("no_deadbeef", down_data == 32'hDEAD_BEEF, 0);
    if (streaming) chk("stream_level_le1", level <= 1, 1);
    pop = exp_dv && down_rdy;
    if (streaming && pop) chk("stream_order", down_data, res_fn(n_pop));
    if (up_vld && !exp_rdy) m_stall++;
    if (exp_dv && !down_rdy) m_drain++;
    if (exp_iss) n_issue++;
    if (pop) n_pop++;
    m_credits = m_credits + (pop ? 1 : 0) - (exp_iss ? 1 : 0);
    full = (m_q.size() == c_depth);
    if (pop) void'(m_q.pop_front());
    if (pipe_res_vld) begin
      if (!full || pop) m_q.push_back(pipe_res);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    up_vld = 1'b0;
    down_rdy = 1'b0;
    force_vld = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  typedef struct {
    bit up_vld;
    bit down_rdy;
    bit exp_rdy;
    bit exp_iss;
    bit exp_dv;
    int exp_lvl;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int iss0;
    streaming = 0;
    no_dead   = 0;
    model_reset();

    // Two issues, results after latency, then drained one per cycle.
    vecs[0]  = '{1, 0, 1, 1, 0, 0};
    vecs[1]  = '{1, 0, 1, 1, 0, 0};
    for (int i = 2; i < 8; i++) vecs[i] = '{0, 0, 1, 0, 0, 0};
    vecs[8]  = '{0, 0, 1, 0, 1, 1};
    vecs[9]  = '{0, 1, 1, 0, 1, 2};
    vecs[10] = '{0, 1, 1, 0, 1, 1};
    vecs[11] = '{0, 0, 1, 0, 0, 0};

    @(posedge clk);
    #1;
    do_reset();
    chk("rst_up_rdy", up_rdy, 1);
    chk("rst_issue_vld", issue_vld, 0);
    chk("rst_down_vld", down_vld, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);

    for (int i = 0; i < 12; i++) begin
      up_vld   = vecs[i].up_vld;
      down_rdy = vecs[i].down_rdy;
      @(negedge clk);
      chk("tbl_up_rdy", up_rdy, vecs[i].exp_rdy);
      chk("tbl_issue", issue_vld, vecs[i].exp_iss);
      chk("tbl_down_vld", down_vld, vecs[i].exp_dv);
      chk("tbl_level", level, vecs[i].exp_lvl);
      model_cycle();
      @(posedge clk);
      #1;
    end

    // Streaming at full rate.
    do_reset();
    streaming = 1;
    down_rdy  = 1'b1;
    up_vld    = 1'b1;
    for (int i = 0; i < 100; i++) step();
    up_vld = 1'b0;
    for (int i = 0; i < c_lat + 3; i++) step();
    streaming = 0;
    chk("stream_issues", n_issue, 100);
    chk("stream_pops", n_pop, 100);

    // Consumer blocked for 40 cycles.
    do_reset();
    up_vld = 1'b1;
    for (int i = 0; i < 40; i++) step();
    chk("blk_issues", n_issue, 16);
    chk("blk_up_rdy", up_rdy, 0);
    chk("blk_level", level, 16);
    chk("blk_overflow", overflow, 0);
`ifdef FORMULA_RES_BUF_PERF_CNT_EN
    chk("perf_stall_cnt", stall_cnt, 24);
    chk("perf_drain_stall_cnt", drain_stall_cnt, 40 - c_lat - 1);
`endif

    // Single-cycle release.
    iss0 = n_issue;
    down_rdy = 1'b1;
    step();
    down_rdy = 1'b0;
    chk("rel_up_rdy", up_rdy, 1);
    for (int i = 0; i < 10; i++) step();
    chk("rel_one_issue", n_issue - iss0, 1);
    chk("rel_level", level, 16);

    // Forced pushes while full: with pop accepted, without pop dropped.
    up_vld     = 1'b0;
    down_rdy   = 1'b1;
    force_vld  = 1'b1;
    force_data = 32'h1234_5678;
    step();
    chk("full_push_pop_level", level, 16);
    chk("full_push_pop_ovf", overflow, 0);
    down_rdy   = 1'b0;
    force_data = 32'hDEAD_BEEF;
    step();
    force_vld  = 1'b0;
    chk("drop_ovf", overflow, 1);
    chk("drop_level", level, 16);
    for (int i = 0; i < 3; i++) step();
    chk("drop_ovf_sticky", overflow, 1);
    no_dead  = 1;
    up_vld   = 1'b1;
    down_rdy = 1'b1;
    for (int i = 0; i < 20; i++) step();
    no_dead  = 0;

    // Asynchronous reset in the middle of traffic.
    #2;
    rst    = 1'b0;
    up_vld = 1'b0;
    #1;
    chk("arst_up_rdy", up_rdy, 1);
    chk("arst_issue_vld", issue_vld, 0);
    chk("arst_down_vld", down_vld, 0);
    chk("arst_level", level, 0);
    chk("arst_overflow", overflow, 0);
`ifdef FORMULA_RES_BUF_PERF_CNT_EN
    chk("arst_stall_cnt", stall_cnt, 0);
    chk("arst_drain_stall_cnt", drain_stall_cnt, 0);
`endif
    @(posedge clk);
    #1;
    do_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      up_vld   = ($urandom_range(0, 3) != 0);
      down_rdy = ($urandom_range(0, 1) != 0);
      step();
    end
    up_vld   = 1'b0;
    down_rdy = 1'b1;
    for (int i = 0; i < c_depth + c_lat + 2; i++) step();
    chk("rand_drained_level", level, 0);
    chk("rand_all_popped", n_pop, n_issue);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
